// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared BTB types, field-extraction helpers and alignment constants
package branch_target_buffer_pkg;

    localparam int PC_ALIGN_BITS = 2;
    // Tag storage is sized for the widest tag any legal BTB_DEPTH/TAG_WIDTH pair can produce;
    // narrower configurations zero-extend, so one entry type serves every parameterisation.
    localparam int TAG_MAX_WIDTH = 32 - PC_ALIGN_BITS;

    typedef struct packed {
        logic                     valid;
        logic [TAG_MAX_WIDTH-1:0] tag;
        logic [31:PC_ALIGN_BITS]  target;
    } btb_entry_t;

    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int depth);
        logic [31:0] mask;
        mask = (32'd1 << depth) - 32'd1;
        return (pc >> PC_ALIGN_BITS) & mask;
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int depth, input int tag_width);
        logic [31:0] mask;
        mask = (tag_width >= 32) ? '1 : ((32'd1 << tag_width) - 32'd1);
        return (pc >> (PC_ALIGN_BITS + depth)) & mask;
    endfunction

    function automatic logic [31:PC_ALIGN_BITS] target_field(input logic [31:0] target);
        return target[31:PC_ALIGN_BITS];
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup, ID register and EX training signals of the BTB
interface branch_target_buffer_if;

    logic [31:0] pcF;
    logic        stallD;
    logic        flushD;
    logic        hitF;
    logic [31:0] targetF;
    logic        hitD;
    logic [31:0] targetD;
    logic        updateE;
    logic [31:0] pcE;
    logic        actual_takeE;
    logic [31:0] targetE;

    modport master (
        output pcF, stallD, flushD, updateE, pcE, actual_takeE, targetE,
        input  hitF, targetF, hitD, targetD
    );

    modport slave (
        input  pcF, stallD, flushD, updateE, pcE, actual_takeE, targetE,
        output hitF, targetF, hitD, targetD
    );

endinterface

// File: rtl/branch_target_buffer_btb_ram.sv
// rtl/branch_target_buffer_btb_ram.sv - BTB storage: async read, sync write, async-reset valid vector
module btb_ram
    import branch_target_buffer_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] rd_index,
    output btb_entry_t       rd_entry,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_index,
    input  btb_entry_t       wr_entry
);

    localparam int ENTRIES = 1 << DEPTH;

    logic [ENTRIES-1:0]       valid_q;
    logic [TAG_MAX_WIDTH-1:0] tag_mem    [ENTRIES];
    logic [31:PC_ALIGN_BITS]  target_mem [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= wr_entry.valid;
        end
    end

    // Payload arrays are unreset; a write coinciding with reset is suppressed so it cannot
    // leave stale data behind an entry that the valid vector has just cleared.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_mem[wr_index]    <= wr_entry.tag;
            target_mem[wr_index] <= wr_entry.target;
        end
    end

    assign rd_entry = '{valid:  valid_q[rd_index],
                        tag:    tag_mem[rd_index],
                        target: target_mem[rd_index]};

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB top; define BTB_BYPASS_EN for same-cycle EX-to-IF forwarding
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int BTB_DEPTH = 6,
    parameter int TAG_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_target_buffer_if.slave bus
);

    logic [BTB_DEPTH-1:0]     idx_f;
    logic [BTB_DEPTH-1:0]     idx_e;
    logic [TAG_MAX_WIDTH-1:0] tag_f;
    logic [TAG_MAX_WIDTH-1:0] tag_e;
    logic                     wr_en;
    btb_entry_t               rd_entry;
    btb_entry_t               wr_entry;
    logic                     hit_lookup;
    logic [31:0]              target_lookup;
    logic                     hit_q;
    logic [31:0]              target_q;

    assign idx_f = BTB_DEPTH'(pc_index(bus.pcF, BTB_DEPTH));
    assign idx_e = BTB_DEPTH'(pc_index(bus.pcE, BTB_DEPTH));
    assign tag_f = TAG_MAX_WIDTH'(pc_tag(bus.pcF, BTB_DEPTH, TAG_WIDTH));
    assign tag_e = TAG_MAX_WIDTH'(pc_tag(bus.pcE, BTB_DEPTH, TAG_WIDTH));

    // Only taken outcomes allocate; not-taken is left to the direction predictor.
    assign wr_en    = bus.updateE && bus.actual_takeE;
    assign wr_entry = '{valid: 1'b1, tag: tag_e, target: target_field(bus.targetE)};

    btb_ram #(
        .DEPTH(BTB_DEPTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .rd_index (idx_f),
        .rd_entry (rd_entry),
        .wr_en    (wr_en),
        .wr_index (idx_e),
        .wr_entry (wr_entry)
    );

    always_comb begin
        hit_lookup    = rd_entry.valid && (rd_entry.tag == tag_f);
        target_lookup = hit_lookup ? {rd_entry.target, {PC_ALIGN_BITS{1'b0}}} : 32'd0;
`ifdef BTB_BYPASS_EN
        if (wr_en && (idx_e == idx_f) && (tag_e == tag_f)) begin
            hit_lookup    = 1'b1;
            target_lookup = {wr_entry.target, {PC_ALIGN_BITS{1'b0}}};
        end
`endif
    end

    assign bus.hitF    = hit_lookup;
    assign bus.targetF = target_lookup;

    // Flush outranks stall so a squashed slot never carries a stale prediction into ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q    <= 1'b0;
            target_q <= 32'd0;
        end else if (bus.flushD) begin
            hit_q    <= 1'b0;
            target_q <= 32'd0;
        end else if (!bus.stallD) begin
            hit_q    <= hit_lookup;
            target_q <= target_lookup;
        end
    end

    assign bus.hitD    = hit_q;
    assign bus.targetD = target_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - table-driven bench with ID-stage scoreboard for branch_target_buffer
module tb_branch_target_buffer;

`ifdef BTB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        upd;
        logic [31:0] pc_e;
        logic        take;
        logic [31:0] tgt_e;
        logic [31:0] pc_f;
        logic        stall;
        logic        flush;
        logic        exp_hit;
        logic [31:0] exp_tgt;
    } vec_t;

    typedef struct {
        logic        hit;
        logic [31:0] tgt;
    } id_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    id_t  sb[$];
    id_t  last_id;

    branch_target_buffer_if bus ();

    branch_target_buffer #(
        .BTB_DEPTH(6),
        .TAG_WIDTH(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic upd, input logic [31:0] pc_e, input logic take,
                       input logic [31:0] tgt_e, input logic [31:0] pc_f, input logic stall,
                       input logic flush, input logic exp_hit, input logic [31:0] exp_tgt);
        vec_t v;
        v = '{upd, pc_e, take, tgt_e, pc_f, stall, flush, exp_hit, exp_tgt};
        vecs.push_back(v);
    endtask

    task automatic pop_check(input int tag);
        id_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty_%0d: got empty queue expected an entry", tag);
        end else begin
            checks--;
            e = sb.pop_front();
            chk1($sformatf("v%0d hitD", tag), bus.hitD, e.hit);
            chk32($sformatf("v%0d targetD", tag), bus.targetD, e.tgt);
        end
    endtask

    task automatic idle_inputs();
        bus.updateE      = 1'b0;
        bus.pcE          = 32'd0;
        bus.actual_takeE = 1'b0;
        bus.targetE      = 32'd0;
        bus.stallD       = 1'b0;
        bus.flushD       = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.pcF = 32'h0000_0040;
        #6;
        chk1("reset hitD", bus.hitD, 1'b0);
        chk32("reset targetD", bus.targetD, 32'd0);
        chk1("reset hitF", bus.hitF, 1'b0);
        #1 rst = 1'b0;

        //   upd  pcE           take tgtE          pcF           stl  fl   hit   target
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0040, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100, 32'h0000_1040, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0040, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0140, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 32'h0000_0140, 1'b1, 32'h0000_0200, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0040, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0140, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        add(1'b1, 32'h0000_0140, 1'b0, 32'h0000_0999, 32'h0000_0140, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0142, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0300, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0140, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0140, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        add(1'b1, 32'h0000_0080, 1'b1, 32'h0000_2007, 32'h0000_0080, 1'b0, 1'b0, BYP,
            BYP ? 32'h0000_2004 : 32'h0);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 1'b1, 32'h0000_2004);
        add(1'b1, 32'h0000_0080, 1'b1, 32'h0000_3000, 32'h0000_0080, 1'b0, 1'b0, 1'b1,
            BYP ? 32'h0000_3000 : 32'h0000_2004);
        add(1'b1, 32'h0000_0080, 1'b1, 32'h0000_4000, 32'h0000_0080, 1'b0, 1'b0, 1'b1,
            BYP ? 32'h0000_4000 : 32'h0000_3000);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 1'b1, 32'h0000_4000);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_1080, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0080, 1'b0, 1'b1, 1'b1, 32'h0000_4000);
        add(1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);

        last_id = '{1'b0, 32'd0};
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i > 0) pop_check(i - 1);
            bus.updateE      = vecs[i].upd;
            bus.pcE          = vecs[i].pc_e;
            bus.actual_takeE = vecs[i].take;
            bus.targetE      = vecs[i].tgt_e;
            bus.pcF          = vecs[i].pc_f;
            bus.stallD       = vecs[i].stall;
            bus.flushD       = vecs[i].flush;
            #2;
            chk1($sformatf("v%0d hitF", i), bus.hitF, vecs[i].exp_hit);
            chk32($sformatf("v%0d targetF", i), bus.targetF, vecs[i].exp_tgt);
            if (vecs[i].flush) last_id = '{1'b0, 32'd0};
            else if (!vecs[i].stall) last_id = '{vecs[i].exp_hit, vecs[i].exp_tgt};
            sb.push_back(last_id);
        end
        @(negedge clk);
        pop_check(vecs.size() - 1);

        // Asynchronous reset mid-cycle clears the ID register and every valid bit at once.
        idle_inputs();
        bus.pcF = 32'h0000_0080;
        @(negedge clk);
        chk1("pre_reset hitD", bus.hitD, 1'b1);
        chk32("pre_reset targetD", bus.targetD, 32'h0000_4000);
        #2 rst = 1'b1;
        #1;
        chk1("async_reset hitD", bus.hitD, 1'b0);
        chk32("async_reset targetD", bus.targetD, 32'd0);
        chk1("async_reset hitF 0x80", bus.hitF, 1'b0);
        bus.pcF = 32'h0000_0040;
        #1 chk1("async_reset hitF 0x40", bus.hitF, 1'b0);
        bus.pcF = 32'h0000_1040;
        #1 chk1("async_reset hitF 0x1040", bus.hitF, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset held across an update edge drops the write.
        bus.updateE      = 1'b1;
        bus.pcE          = 32'h0000_00C0;
        bus.actual_takeE = 1'b1;
        bus.targetE      = 32'h0000_0500;
        bus.pcF          = 32'h0000_00C0;
        #4 rst = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        chk1("reset_during_update hitF", bus.hitF, 1'b0);
        chk32("reset_during_update targetF", bus.targetF, 32'd0);
        chk1("reset_during_update hitD", bus.hitD, 1'b0);

        // Training still works once reset is released.
        bus.updateE      = 1'b1;
        bus.pcE          = 32'h0000_00C0;
        bus.actual_takeE = 1'b1;
        bus.targetE      = 32'h0000_0500;
        @(negedge clk);
        idle_inputs();
        #1;
        chk1("retrain hitF", bus.hitF, 1'b1);
        chk32("retrain targetF", bus.targetF, 32'h0000_0500);
        @(negedge clk);
        chk1("retrain hitD", bus.hitD, 1'b1);
        chk32("retrain targetD", bus.targetD, 32'h0000_0500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
